ivs_frm_rd_addr_gen: RTL

- Downstream neighbour of the slot command manager. Consumes the decoded frame descriptor (frm_* fields) after a command response.
- Walks the input frame tile by tile. Issues one DMA read-address request per tile line on a valid/ready channel.
- Feeds the DMA read engine. Sideband flags mark tile and frame boundaries for the pixel-processing stage.

---
 rtl/ivs_pkg.sv | 23 ++
 rtl/ivs_frm_rd_addr_gen_if.sv | 32 +++
 rtl/ivs_tile_cnt.sv | 44 ++++
 rtl/ivs_frm_rd_addr_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ivs_pkg.sv
// ============================================================================
// Package  : ivs_pkg
// Purpose  : Shared constants and FSM encoding for the frame read-address path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ivs_pkg;

    localparam int c_BEAT_BYTES = 8;
    localparam int c_FIELD_W    = 16;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_CHECK = 3'd1;
    localparam state_t c_ST_REQ   = 3'd2;
    localparam state_t c_ST_DONE  = 3'd3;
    localparam state_t c_ST_ERR   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ivs_frm_rd_addr_gen_if.sv
// ============================================================================
// Interface : ivs_frm_rd_addr_gen_if
// Purpose   : DMA read-address request channel with tile/frame sideband flags.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ivs_frm_rd_addr_gen_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5
);

    logic              ar_vld;
    logic              ar_rdy;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic              ar_tile_last;
    logic              ar_frm_last;

    modport master (
        output ar_vld, ar_addr, ar_len, ar_tile_last, ar_frm_last,
        input  ar_rdy
    );

    modport slave (
        input  ar_vld, ar_addr, ar_len, ar_tile_last, ar_frm_last,
        output ar_rdy
    );

endinterface

`default_nettype wire

// File: rtl/ivs_tile_cnt.sv
// ============================================================================
// Module   : ivs_tile_cnt
// Purpose  : Step counter with a last-step flag and the step clipped to limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ivs_tile_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W:0]   i_load_val,
    input  logic         i_adv,
    input  logic [W-1:0] i_step,
    input  logic [W-1:0] i_limit,
    output logic [W:0]   o_pos,
    output logic         o_last,
    output logic [W-1:0] o_rem
);

    // The extra top bit keeps pos + step from wrapping for any 16-bit operands.
    logic [W:0] r_pos;
    logic [W:0] w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= '0;
        end else if (i_load) begin
            r_pos <= i_load_val;
        end else if (i_adv) begin
            r_pos <= w_next;
        end
    end

    assign w_next = r_pos + {1'b0, i_step};
    assign o_pos  = r_pos;
    assign o_last = (w_next >= {1'b0, i_limit});
    assign o_rem  = o_last ? W'({1'b0, i_limit} - r_pos) : i_step;

endmodule

`default_nettype wire

// File: rtl/ivs_frm_rd_addr_gen.sv
// ============================================================================
// Module   : ivs_frm_rd_addr_gen
// Purpose  : Walks a frame tile by tile, one DMA read request per tile line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ivs_frm_rd_addr_gen
    import ivs_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = c_BEAT_BYTES,
    parameter int LEN_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frm_start,
    input  logic [c_FIELD_W-1:0] frm_width,
    input  logic [c_FIELD_W-1:0] frm_height,
    input  logic [c_FIELD_W-1:0] frm_x_step,
    input  logic [c_FIELD_W-1:0] frm_y_step,
    input  logic [c_FIELD_W-1:0] frm_line_stride,
    input  logic [ADDR_W-1:0]    frm_i_base,
    ivs_frm_rd_addr_gen_if.master ar,
    output logic                 busy,
    output logic                 frm_done,
    output logic                 frm_err
);

    localparam logic [c_FIELD_W-1:0] c_MAX_XSTEP = c_FIELD_W'(BEAT_BYTES << LEN_W);

    state_t r_state;
    state_t w_state_nxt;

    logic [c_FIELD_W-1:0] r_width, r_height, r_x_step, r_y_step, r_stride, r_ly;
    logic [ADDR_W-1:0]    r_base, r_row_base, r_line_base;

    logic                 w_accept, w_xfer, w_desc_bad;
    logic                 w_tile_last, w_x_last, w_y_last, w_frm_last;
    logic [c_FIELD_W:0]   w_x_pos, w_y_pos;
    logic [c_FIELD_W-1:0] w_x_rem, w_y_rem;
    logic                 w_unused_y;

    assign w_accept    = (r_state == c_ST_IDLE) && frm_start;
    assign w_xfer      = (r_state == c_ST_REQ) && ar.ar_rdy;
    assign w_tile_last = (({1'b0, r_ly} + 17'd1) == {1'b0, w_y_rem});
    assign w_frm_last  = w_tile_last && w_x_last && w_y_last;

    // Row position is carried by r_row_base; only the flags are needed here.
    assign w_unused_y  = ^w_y_pos;

    assign w_desc_bad = (r_width == '0) || (r_height == '0) ||
                        (r_x_step == '0) || (r_y_step == '0) ||
                        (r_x_step > c_MAX_XSTEP) ||
                        ((r_base % ADDR_W'(BEAT_BYTES)) != '0) ||
                        ((r_stride % c_FIELD_W'(BEAT_BYTES)) != '0) ||
                        ((r_x_step % c_FIELD_W'(BEAT_BYTES)) != '0);

    ivs_tile_cnt #(.W(c_FIELD_W)) u_x_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept || (w_xfer && w_tile_last && w_x_last)),
        .i_load_val ('0),
        .i_adv      (w_xfer && w_tile_last && !w_x_last),
        .i_step     (r_x_step),
        .i_limit    (r_width),
        .o_pos      (w_x_pos),
        .o_last     (w_x_last),
        .o_rem      (w_x_rem)
    );

    ivs_tile_cnt #(.W(c_FIELD_W)) u_y_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val ('0),
        .i_adv      (w_xfer && w_tile_last && w_x_last && !w_y_last),
        .i_step     (r_y_step),
        .i_limit    (r_height),
        .o_pos      (w_y_pos),
        .o_last     (w_y_last),
        .o_rem      (w_y_rem)
    );

    // r_line_base tracks base + (y+ly)*stride; a full non-final tile row has
    // exactly y_step lines, so the next row starts one stride past its last line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_width     <= '0;
            r_height    <= '0;
            r_x_step    <= '0;
            r_y_step    <= '0;
            r_stride    <= '0;
            r_base      <= '0;
            r_row_base  <= '0;
            r_line_base <= '0;
            r_ly        <= '0;
        end else if (w_accept) begin
            r_width     <= frm_width;
            r_height    <= frm_height;
            r_x_step    <= frm_x_step;
            r_y_step    <= frm_y_step;
            r_stride    <= frm_line_stride;
            r_base      <= frm_i_base;
            r_row_base  <= frm_i_base;
            r_line_base <= frm_i_base;
            r_ly        <= '0;
        end else if (w_xfer) begin
            if (!w_tile_last) begin
                r_ly        <= r_ly + 1'b1;
                r_line_base <= r_line_base + ADDR_W'(r_stride);
            end else begin
                r_ly <= '0;
                if (!w_x_last) begin
                    r_line_base <= r_row_base;
                end else if (!w_y_last) begin
                    r_line_base <= r_line_base + ADDR_W'(r_stride);
                    r_row_base  <= r_line_base + ADDR_W'(r_stride);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (frm_start) w_state_nxt = c_ST_CHECK;
            c_ST_CHECK: w_state_nxt = w_desc_bad ? c_ST_ERR : c_ST_REQ;
            c_ST_REQ:   if (w_xfer && w_frm_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            c_ST_ERR:   w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy            = 1'b0;
        frm_done        = 1'b0;
        frm_err         = 1'b0;
        ar.ar_vld       = 1'b0;
        ar.ar_addr      = '0;
        ar.ar_len       = '0;
        ar.ar_tile_last = 1'b0;
        ar.ar_frm_last  = 1'b0;
        case (r_state)
            c_ST_CHECK: busy = 1'b1;
            c_ST_REQ: begin
                busy            = 1'b1;
                ar.ar_vld       = 1'b1;
                ar.ar_addr      = r_line_base + ADDR_W'(w_x_pos);
                ar.ar_len       = LEN_W'((w_x_rem - c_FIELD_W'(1)) / c_FIELD_W'(BEAT_BYTES));
                ar.ar_tile_last = w_tile_last;
                ar.ar_frm_last  = w_frm_last;
            end
            c_ST_DONE: frm_done = 1'b1;
            c_ST_ERR:  frm_err  = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire
